// File: rtl/dmem_arbiter_if.sv
// Request, grant, read-return and RAM-drive signals between the two data-RAM
// requesters, the arbiter and the single-port RAM.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              p_req;
  logic              p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic              a_boost;

  logic              mem_wEn;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dataIn;
  logic [DATA_W-1:0] mem_dataOut;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    input  a_req, a_we, a_addr, a_wdata,
    input  mem_dataOut,
    output p_gnt, p_rvalid, p_rdata,
    output a_gnt, a_rvalid, a_rdata, a_boost,
    output mem_wEn, mem_addr, mem_dataIn
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    output a_req, a_we, a_addr, a_wdata,
    output mem_dataOut,
    input  p_gnt, p_rvalid, p_rdata,
    input  a_gnt, a_rvalid, a_rdata, a_boost,
    input  mem_wEn, mem_addr, mem_dataIn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: P has fixed priority, A is
// protected by a saturating starvation counter; read data is routed by a tag pipe.
module dmem_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  cnt;
  logic              boost;
  logic              a_gnt;
  logic              p_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              rd_issue;
  logic [RD_LAT-1:0] pv;
  logic [RD_LAT-1:0] po;

  assign boost = (cnt == CNT_MAX);

  // Grants are gated by reset so nothing reaches the RAM while it is held.
  assign a_gnt = reset & bus.a_req & (~bus.p_req | boost);
  assign p_gnt = reset & bus.p_req & ~a_gnt;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (a_gnt) begin
      win_we    = bus.a_we;
      win_addr  = bus.a_addr;
      win_wdata = bus.a_wdata;
    end else if (p_gnt) begin
      win_we    = bus.p_we;
      win_addr  = bus.p_addr;
      win_wdata = bus.p_wdata;
    end
  end

  assign rd_issue = (a_gnt | p_gnt) & ~win_we;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (bus.a_req && !a_gnt) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Tag pipe: pv marks a pending read, po its owner (1 = A).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      po <= '0;
    end else begin
      pv[0] <= rd_issue;
      po[0] <= a_gnt;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        po[i] <= po[i-1];
      end
    end
  end

  assign bus.a_gnt      = a_gnt;
  assign bus.p_gnt      = p_gnt;
  assign bus.a_boost    = boost;
  assign bus.mem_wEn    = win_we;
  assign bus.mem_addr   = win_addr;
  assign bus.mem_dataIn = win_wdata;
  assign bus.p_rvalid   = pv[RD_LAT-1] & ~po[RD_LAT-1];
  assign bus.a_rvalid   = pv[RD_LAT-1] &  po[RD_LAT-1];
  assign bus.p_rdata    = bus.mem_dataOut;
  assign bus.a_rdata    = bus.mem_dataOut;
endmodule
